sc_lives_downcounter: RTL

Lives manager for the Frogger player. It loads the starting life count and removes one life on each death event. After each non-fatal death it holds a fixed-length respawn hold-off. It adds extra lives on bonus events and raises a game-over flag when the count reaches zero. It sits between the collision/bonus logic (active-low event inputs) and the score/display path, which consumes the life count and the game-over flag.

---
 rtl/sc_lives_downcounter.sv | 119 +++++++++++
 1 files changed

// File: rtl/sc_lives_downcounter.sv
// rtl/sc_lives_downcounter.sv - Frogger lives manager: death/bonus events, respawn hold-off, game over
//
// Ports:
//   SC_LIVES_DOWNCOUNTER_CLOCK_50        in   system clock, rising edge
//   SC_LIVES_DOWNCOUNTER_RESET_InLow     in   asynchronous reset, active-low
//   SC_LIVES_DOWNCOUNTER_load_InLow      in   synchronous new-game reload, level, active-low
//   SC_LIVES_DOWNCOUNTER_downcount_InLow in   death request, falling edge = one event
//   SC_LIVES_DOWNCOUNTER_addlife_InLow   in   bonus request, falling edge = one event
//   SC_LIVES_DOWNCOUNTER_lives_Out       out  current life count
//   SC_LIVES_DOWNCOUNTER_respawn_OutLow  out  low during respawn hold-off
//   SC_LIVES_DOWNCOUNTER_gameover_OutHigh out high in GAMEOVER
module sc_lives_downcounter #(
  parameter int LIVES_DOWNCOUNTER_DATAWIDTH       = 3,
  parameter int LIVES_DOWNCOUNTER_INIT            = 3,
  parameter int LIVES_DOWNCOUNTER_RESPAWN_CYCLES  = 8
) (
  input  logic                                   SC_LIVES_DOWNCOUNTER_CLOCK_50,
  input  logic                                   SC_LIVES_DOWNCOUNTER_RESET_InLow,
  input  logic                                   SC_LIVES_DOWNCOUNTER_load_InLow,
  input  logic                                   SC_LIVES_DOWNCOUNTER_downcount_InLow,
  input  logic                                   SC_LIVES_DOWNCOUNTER_addlife_InLow,
  output logic [LIVES_DOWNCOUNTER_DATAWIDTH-1:0] SC_LIVES_DOWNCOUNTER_lives_Out,
  output logic                                   SC_LIVES_DOWNCOUNTER_respawn_OutLow,
  output logic                                   SC_LIVES_DOWNCOUNTER_gameover_OutHigh
);

  localparam int W = LIVES_DOWNCOUNTER_DATAWIDTH;
  localparam logic [W-1:0] LIVES_INIT   = W'(LIVES_DOWNCOUNTER_INIT);
  localparam logic [W-1:0] LIVES_ONE    = W'(1);
  localparam logic [W-1:0] LIVES_MAX    = '1;
  localparam logic [15:0]  RESPAWN_LOAD = 16'(LIVES_DOWNCOUNTER_RESPAWN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_PLAY,
    ST_RESPAWN,
    ST_GAMEOVER
  } state_t;

  state_t         state;
  logic [W-1:0]   lives;
  logic [15:0]    timer;
  logic           down_prev;
  logic           add_prev;

  logic           down_event;
  logic           add_event;
  logic [W-1:0]   lives_inc;

  // Previous samples reset to 1 so an input already low at reset release
  // counts as one fresh event; a held-low input never re-triggers.
  assign down_event = ~SC_LIVES_DOWNCOUNTER_downcount_InLow & down_prev;
  assign add_event  = ~SC_LIVES_DOWNCOUNTER_addlife_InLow   & add_prev;
  assign lives_inc  = (lives == LIVES_MAX) ? lives : lives + LIVES_ONE;

  always_ff @(posedge SC_LIVES_DOWNCOUNTER_CLOCK_50 or negedge SC_LIVES_DOWNCOUNTER_RESET_InLow) begin
    if (!SC_LIVES_DOWNCOUNTER_RESET_InLow) begin
      state     <= ST_PLAY;
      lives     <= LIVES_INIT;
      timer     <= '0;
      down_prev <= 1'b1;
      add_prev  <= 1'b1;
    end else begin
      // Edge registers sample every cycle, whatever the state, so events
      // ignored during invulnerability are not queued.
      down_prev <= SC_LIVES_DOWNCOUNTER_downcount_InLow;
      add_prev  <= SC_LIVES_DOWNCOUNTER_addlife_InLow;

      if (!SC_LIVES_DOWNCOUNTER_load_InLow) begin
        state <= ST_PLAY;
        lives <= LIVES_INIT;
        timer <= '0;
      end else begin
        case (state)
          ST_PLAY: begin
            if (down_event && add_event) begin
              // Decrement then saturating increment nets to the same count,
              // and lives >= 1 here, so this can never reach GAMEOVER.
              state <= ST_RESPAWN;
              timer <= RESPAWN_LOAD;
            end else if (down_event) begin
              if (lives > LIVES_ONE) begin
                lives <= lives - LIVES_ONE;
                state <= ST_RESPAWN;
                timer <= RESPAWN_LOAD;
              end else begin
                lives <= '0;
                state <= ST_GAMEOVER;
              end
            end else if (add_event) begin
              lives <= lives_inc;
            end
          end
          ST_RESPAWN: begin
            if (add_event) begin
              lives <= lives_inc;
            end
            // Timer loaded with N-1 and exits on 0 gives exactly N cycles low.
            if (timer == 16'd0) begin
              state <= ST_PLAY;
            end else begin
              timer <= timer - 16'd1;
            end
          end
          ST_GAMEOVER: begin
            state <= ST_GAMEOVER;
          end
          default: begin
            state <= ST_PLAY;
          end
        endcase
      end
    end
  end

  assign SC_LIVES_DOWNCOUNTER_lives_Out        = lives;
  assign SC_LIVES_DOWNCOUNTER_respawn_OutLow   = (state != ST_RESPAWN);
  assign SC_LIVES_DOWNCOUNTER_gameover_OutHigh = (state == ST_GAMEOVER);

endmodule
